// File: rtl/lift_controller_n_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lift_controller_n_if
//  Purpose  : Board-side signal bundle for the FLOORS-landing lift controller.
//             The master modport is the board/bench side: it drives sensors,
//             buttons and emergency inputs. The slave modport is the
//             controller: it drives motor, direction, lamps and status.
//  Revision : 1.0  initial release
// ============================================================================
interface lift_controller_n_if #(
  parameter int FLOORS = 4
);
  localparam int PW = $clog2(FLOORS);

  // Inputs to the controller (all active-low)
  logic [FLOORS-1:0] floor_n;
  logic [FLOORS-1:0] call_n;
  logic              emergency_n;
  logic              em_cancel_n;

  // Outputs from the controller
  logic              direction;
  logic              enable_n;
  logic [FLOORS-1:0] indicator_n;
  logic [PW-1:0]     position;
  logic [1:0]        state_code;

  modport master (
    output floor_n, call_n, emergency_n, em_cancel_n,
    input  direction, enable_n, indicator_n, position, state_code
  );

  modport slave (
    input  floor_n, call_n, emergency_n, em_cancel_n,
    output direction, enable_n, indicator_n, position, state_code
  );
endinterface
`default_nettype wire

// File: rtl/lift_controller_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : lift_controller_n
//  Purpose  : Collective (up/down sweep) lift controller for FLOORS landings.
//             Latches active-low calls, tracks the car from active-low landing
//             sensors, times the door dwell internally and drives the
//             active-low motor enable plus direction. Emergency stop/cancel.
//  Revision : 1.0  initial release
// ============================================================================
module lift_controller_n #(
  parameter int FLOORS = 4,
  parameter int DWELL  = 50000000
) (
  input  wire logic         clock,
  input  wire logic         n_reset,
  lift_controller_n_if.slave bus
);

  localparam int PW = $clog2(FLOORS);
  localparam int CW = $clog2(DWELL);
  localparam logic [CW-1:0] c_dwell_last = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    HOME  = 2'd0,
    MOVE  = 2'd1,
    AT    = 2'd2,
    ESTOP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_dir;
  logic              w_dir_next;
  logic [PW-1:0]     r_position;
  logic [PW-1:0]     r_depart;
  logic [PW-1:0]     w_depart_next;
  logic [FLOORS-1:0] r_pending;
  logic [FLOORS-1:0] w_clear;
  logic [FLOORS-1:0] w_pending_next;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_next;

  logic              w_any_floor;
  logic [PW-1:0]     w_floor_idx;
  logic              w_above;
  logic              w_below;
  logic              w_stop;
  logic              w_call_here;
  logic              w_timeout;
  logic              w_enable_n;

  // Decode landing sensors; the descending scan leaves the lowest active index
  always_comb begin
    w_any_floor = 1'b0;
    w_floor_idx = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (!bus.floor_n[i]) begin
        w_any_floor = 1'b1;
        w_floor_idx = PW'(i);
      end
    end
  end

  // Pending calls above/below the car, and the stop condition while moving.
  // The departure floor is excluded so the car can leave its own sensor.
  // Terminal landings always stop the car to keep it from overrunning.
  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    w_stop  = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (r_pending[i] && (PW'(i) > r_position)) w_above = 1'b1;
      if (r_pending[i] && (PW'(i) < r_position)) w_below = 1'b1;
      if (!bus.floor_n[i] && (PW'(i) != r_depart) &&
          (r_pending[i] || (i == 0) || (i == FLOORS - 1)))
        w_stop = 1'b1;
    end
  end

  assign w_call_here = ~bus.call_n[r_position];
  assign w_timeout   = (r_count == c_dwell_last);

  // Per-floor clear: everything clears in ESTOP, the served floor clears in AT
  generate
    for (genvar g = 0; g < FLOORS; g++) begin : g_clear
      assign w_clear[g] = (r_state == ESTOP) ||
                          ((r_state == AT) && (r_position == PW'(g)));
    end
  endgenerate

  // Clear wins over a simultaneous press
  assign w_pending_next = (r_pending | ~bus.call_n) & ~w_clear;

  // Next-state, direction, dwell count and motor enable
  always_comb begin
    w_state_next  = r_state;
    w_dir_next    = r_dir;
    w_count_next  = r_count;
    w_depart_next = r_depart;
    w_enable_n    = 1'b0;
    case (r_state)
      HOME: begin
        // Run down until the bottom sensor is reached
        w_dir_next = 1'b0;
        w_enable_n = ~bus.floor_n[0];
        if (!bus.floor_n[0]) begin
          w_state_next = AT;
          w_count_next = '0;
        end
      end
      MOVE: begin
        w_enable_n = w_stop;
        if (w_stop) begin
          w_state_next = AT;
          w_count_next = '0;
        end
      end
      AT: begin
        w_enable_n = 1'b1;
        // A press at the current floor reopens the door and restarts dwell
        if (w_call_here)
          w_count_next = '0;
        else if (!w_timeout)
          w_count_next = r_count + 1'b1;
        if (w_timeout && !w_call_here) begin
          if (w_above && (r_dir || !w_below)) begin
            w_dir_next    = 1'b1;
            w_state_next  = MOVE;
            w_depart_next = r_position;
          end else if (w_below) begin
            w_dir_next    = 1'b0;
            w_state_next  = MOVE;
            w_depart_next = r_position;
          end
        end
      end
      ESTOP: begin
        w_enable_n = 1'b1;
        if (!bus.em_cancel_n) begin
          w_state_next = HOME;
          w_dir_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = HOME;
      end
    endcase
    // Emergency overrides every other transition, including cancel
    if (!bus.emergency_n)
      w_state_next = ESTOP;
  end

  // State, position, pending calls and dwell counter registers
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= HOME;
      r_dir      <= 1'b0;
      r_position <= '0;
      r_depart   <= '0;
      r_pending  <= '0;
      r_count    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_dir     <= w_dir_next;
      r_depart  <= w_depart_next;
      r_pending <= w_pending_next;
      r_count   <= w_count_next;
      if (w_any_floor)
        r_position <= w_floor_idx;
    end
  end

  assign bus.direction   = r_dir;
  assign bus.enable_n    = w_enable_n;
  assign bus.indicator_n = ~r_pending;
  assign bus.position    = r_position;
  assign bus.state_code  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lift_controller_n.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_lift_controller_n
//  Purpose  : Directed self-checking bench for lift_controller_n with
//             FLOORS=4, DWELL=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lift_controller_n;

  localparam int FLOORS = 4;
  localparam int DWELL  = 4;

  logic clock = 1'b0;
  logic n_reset;
  int   n_checks = 0;
  int   n_passed = 0;

  lift_controller_n_if #(.FLOORS(FLOORS)) bus ();

  lift_controller_n #(.FLOORS(FLOORS), .DWELL(DWELL)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .bus     (bus)
  );

  // 100 MHz clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [FLOORS-1:0] mask);
    bus.call_n = ~mask;
    step();
    bus.call_n = '1;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] code, input int budget);
    for (int i = 0; i < budget && bus.state_code != code; i++) step();
    check(tag, bus.state_code, code);
  endtask

  // Hard stop in case something wedges the run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.floor_n     = '1;
    bus.call_n      = '1;
    bus.emergency_n = 1'b1;
    bus.em_cancel_n = 1'b1;
    n_reset         = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_state", bus.state_code, 0);
    check("rst_dir", bus.direction, 0);
    check("rst_ind", bus.indicator_n, 4'b1111);
    check("rst_pos", bus.position, 0);
    check("rst_en", bus.enable_n, 0);
    n_reset = 1'b1;

    // Homing onto floor 0
    bus.floor_n = 4'b1110;
    #1;
    check("home_en_stop", bus.enable_n, 1);
    step();
    check("home_at", bus.state_code, 2);
    check("home_pos", bus.position, 0);
    repeat (5) step();
    check("idle_state", bus.state_code, 2);
    check("idle_en", bus.enable_n, 1);

    // Call floor 3, sweep past 1 and 2 without stopping
    press(4'b1000);
    check("c3_ind", bus.indicator_n, 4'b0111);
    step();
    check("c3_move", bus.state_code, 1);
    check("c3_dir", bus.direction, 1);
    check("c3_en", bus.enable_n, 0);
    bus.floor_n = 4'b1111;
    step();
    check("c3_gap_pos", bus.position, 0);
    bus.floor_n = 4'b1101;
    #1;
    check("c3_pass1_en", bus.enable_n, 0);
    step();
    check("c3_pos1", bus.position, 1);
    bus.floor_n = 4'b1011;
    step();
    check("c3_pos2", bus.position, 2);
    check("c3_still_move", bus.state_code, 1);
    bus.floor_n = 4'b0111;
    #1;
    check("c3_stop_en", bus.enable_n, 1);
    step();
    check("c3_at", bus.state_code, 2);
    check("c3_pos3", bus.position, 3);
    step();
    check("c3_served", bus.indicator_n, 4'b1111);

    // Down to floor 0 without stopping at 2 or 1
    press(4'b0001);
    wait_state("d0_move", 1, 10);
    check("d0_dir", bus.direction, 0);
    bus.floor_n = 4'b1111; step();
    bus.floor_n = 4'b1011; step();
    bus.floor_n = 4'b1101; step();
    check("d0_pass1", bus.state_code, 1);
    bus.floor_n = 4'b1110; step();
    check("d0_at", bus.state_code, 2);
    check("d0_pos", bus.position, 0);

    // Up to floor 1, then calls 0 and 2: up-first sweep to 2, then 0
    press(4'b0010);
    wait_state("u1_move", 1, 10);
    bus.floor_n = 4'b1111; step();
    bus.floor_n = 4'b1101; step();
    check("u1_at", bus.state_code, 2);
    check("u1_pos", bus.position, 1);
    check("u1_dir", bus.direction, 1);
    press(4'b0101);
    check("sw_ind", bus.indicator_n, 4'b1010);
    wait_state("sw_move_up", 1, 10);
    check("sw_dir_up", bus.direction, 1);
    bus.floor_n = 4'b1111; step();
    bus.floor_n = 4'b1011; step();
    check("sw_at2", bus.state_code, 2);
    check("sw_pos2", bus.position, 2);
    wait_state("sw_move_dn", 1, 10);
    check("sw_dir_dn", bus.direction, 0);
    bus.floor_n = 4'b1111; step();
    bus.floor_n = 4'b1101; step();
    check("sw_pass1", bus.state_code, 1);
    bus.floor_n = 4'b1110; step();
    check("sw_at0", bus.state_code, 2);
    step();
    check("sw_ind_clr", bus.indicator_n, 4'b1111);

    // Emergency during MOVE, cancel blocked while emergency held
    press(4'b1000);
    wait_state("em_move", 1, 10);
    bus.floor_n = 4'b1111; step();
    bus.emergency_n = 1'b0;
    step();
    check("em_state", bus.state_code, 3);
    check("em_en", bus.enable_n, 1);
    step();
    check("em_clr", bus.indicator_n, 4'b1111);
    bus.em_cancel_n = 1'b0;
    step();
    check("em_both", bus.state_code, 3);
    bus.emergency_n = 1'b1;
    step();
    check("em_cancel", bus.state_code, 0);
    check("em_dir", bus.direction, 0);
    bus.em_cancel_n = 1'b1;
    #1;
    check("em_home_en", bus.enable_n, 0);
    bus.floor_n = 4'b1110;
    step();
    check("em_home_at", bus.state_code, 2);

    // Door reopen: hold call at the current floor for 6 cycles
    press(4'b1000);
    bus.call_n = 4'b1110;
    repeat (6) step();
    check("ro_hold", bus.state_code, 2);
    check("ro_ind", bus.indicator_n, 4'b0111);
    bus.call_n = 4'b1111;
    repeat (3) step();
    check("ro_wait", bus.state_code, 2);
    step();
    check("ro_depart", bus.state_code, 1);
    check("ro_dir", bus.direction, 1);

    // Same-cycle press at a passing floor does not stop the car
    bus.floor_n = 4'b1111; step();
    bus.floor_n = 4'b1101;
    bus.call_n  = 4'b1101;
    #1;
    check("late_en", bus.enable_n, 0);
    step();
    bus.call_n = 4'b1111;
    check("late_state", bus.state_code, 1);
    check("late_ind", bus.indicator_n, 4'b0101);
    bus.floor_n = 4'b1011;
    step();
    check("mr_pos2", bus.position, 2);
    check("mr_move", bus.state_code, 1);

    // Asynchronous reset mid-move
    n_reset = 1'b0;
    #1;
    check("mr_state", bus.state_code, 0);
    check("mr_ind", bus.indicator_n, 4'b1111);
    check("mr_dir", bus.direction, 0);
    check("mr_pos", bus.position, 0);
    step();
    n_reset = 1'b1;

    // Several sensors low: lowest index wins
    bus.floor_n = 4'b1001;
    step();
    check("multi_pos", bus.position, 1);
    check("multi_home", bus.state_code, 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
